// File: rtl/multiplicador_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mult_state_t;

    // Step counter width: max(1, clog2(n)) so N=1 still gets a 1-bit counter.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiplicador_seq.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock, 2N-bit registered product.
// Optional macro MULTIPLICADOR_SEQ_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module multiplicador_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P
);
    import multiplicador_pkg::*;

    localparam int            CW         = count_width(N);
    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

    mult_state_t     state;
    mult_state_t     next_state;
    logic [2*N-1:0]  acc;
    logic [2*N-1:0]  mcand;
    logic [N-1:0]    mplier;
    logic [CW-1:0]   count;
    logic [2*N-1:0]  product;
    logic [2*N-1:0]  acc_sum;
    logic            last_step;

    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

`ifdef MULTIPLICADOR_SEQ_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this step's shift.
    assign last_step = (count == LAST_COUNT) || ((mplier >> 1) == '0);
`else
    assign last_step = (count == LAST_COUNT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (in_valid)  next_state = CALC;
            CALC: if (last_step) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    // The product register is only written on the final step, so it stays put through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= '0;
                        mcand  <= {{N{1'b0}}, A};
                        mplier <= B;
                        count  <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_step) begin
                        product <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign P         = product;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq at N=4: vector table plus back-pressure, back-to-back and reset sequences.
module tb_multiplicador_seq;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] P;

    int checks;
    int errors;
    logic [2*N-1:0] sb_q[$];

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        int             hold;
    } vec_t;

    vec_t vecs[9];

    multiplicador_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference latency: N edges, or position of B's top set bit when early exit is built in.
    function automatic int exp_latency(input logic [N-1:0] b);
        int hi;
        hi = 0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) hi = i + 1;
        end
`ifdef MULTIPLICADOR_SEQ_EARLY_EXIT_EN
        return (hi < 1) ? 1 : hi;
`else
        return (hi >= 0) ? N : N;
`endif
    endfunction

    task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_result(input int lat_exp, input string name);
        int edges;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check_eq({name, "_out_valid_seen"}, 16'(out_valid), 16'd1);
        check_eq({name, "_latency"}, 16'(edges), 16'(lat_exp));
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [2*N-1:0] p_exp, input string name);
        check_eq({name, "_in_ready"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = N'($urandom);
        B = N'($urandom);
        sb_q.push_back(p_exp);
        check_eq({name, "_busy"}, 16'(in_ready), 16'd0);
        wait_result(exp_latency(b), name);
    endtask

    task automatic checkOutput(input int hold, input string name);
        logic [2*N-1:0] exp_p;
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            check_eq({name, "_hold_valid"}, 16'(out_valid), 16'd1);
            check_eq({name, "_hold_P"}, 16'(P), 16'(exp_p));
            check_eq({name, "_hold_in_ready"}, 16'(in_ready), 16'd0);
            @(posedge clk); #1;
        end
        check_eq({name, "_P"}, 16'(P), 16'(exp_p));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({name, "_valid_drop"}, 16'(out_valid), 16'd0);
        check_eq({name, "_idle"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        vecs[0] = '{a: 4'd13, b: 4'd11, p: 8'd143, hold: 0};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'd225, hold: 0};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'd0,   hold: 0};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  p: 8'd0,   hold: 0};
        vecs[4] = '{a: 4'd7,  b: 4'd6,  p: 8'd42,  hold: 5};
        vecs[5] = '{a: 4'd12, b: 4'd1,  p: 8'd12,  hold: 0};
        vecs[6] = '{a: 4'd12, b: 4'd3,  p: 8'd36,  hold: 0};
        vecs[7] = '{a: 4'd12, b: 4'd8,  p: 8'd96,  hold: 0};
        vecs[8] = '{a: 4'd1,  b: 4'd1,  p: 8'd1,   hold: 2};

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        A         = 4'd5;
        B         = 4'd3;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 16'(in_ready), 16'd1);
        check_eq("rst_out_valid", 16'(out_valid), 16'd0);
        check_eq("rst_P", 16'(P), 16'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", 16'(in_ready), 16'd1);
        check_eq("post_rst_out_valid", 16'(out_valid), 16'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
            checkOutput(vecs[i].hold, $sformatf("vec%0d", i));
        end

        // Back-to-back: operands offered on the DONE->IDLE edge are taken one edge later.
        applyStimulus(4'd6, 4'd7, 8'd42, "b2b_first");
        check_eq("b2b_first_P", 16'(P), 16'd42);
        void'(sb_q.pop_front());
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 4'd2;
        B = 4'd3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("b2b_done_edge_valid", 16'(out_valid), 16'd0);
        check_eq("b2b_not_accepted", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("b2b_accepted", 16'(in_ready), 16'd0);
        sb_q.push_back(8'd6);
        wait_result(exp_latency(4'd3), "b2b_second");
        checkOutput(1, "b2b_second");

        // Reset while calculating discards the operation and clears P.
        in_valid = 1'b1;
        A = 4'd5;
        B = 4'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 16'(in_ready), 16'd1);
        check_eq("midrst_out_valid", 16'(out_valid), 16'd0);
        check_eq("midrst_P", 16'(P), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("midrst_no_valid", 16'(out_valid), 16'd0);
        end
        applyStimulus(4'd3, 4'd4, 8'd12, "after_rst");
        checkOutput(0, "after_rst");

        check_eq("scoreboard_empty", 16'(sb_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
